// File: rtl/ws2812_serializer.sv
// WS2812B single-wire serializer: takes 24-bit GRB pixels over valid/ready and
// emits MSB-first bit waveforms, with a low latch gap after each full frame.
module ws2812_serializer #(
  parameter int unsigned NUM_PIXELS   = 64,
  parameter int unsigned BIT_CYCLES   = 15,
  parameter int unsigned T0H_CYCLES   = 4,
  parameter int unsigned T1H_CYCLES   = 8,
  parameter int unsigned LATCH_CYCLES = 720
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        data_out,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned CYC_MAX = (LATCH_CYCLES > BIT_CYCLES) ? LATCH_CYCLES : BIT_CYCLES;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);
  localparam int unsigned PIX_W   = $clog2(NUM_PIXELS + 1);

  localparam logic [CYC_W-1:0] BIT_LAST   = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] LATCH_LAST = CYC_W'(LATCH_CYCLES - 1);
  localparam logic [CYC_W-1:0] T0H        = CYC_W'(T0H_CYCLES);
  localparam logic [CYC_W-1:0] T1H        = CYC_W'(T1H_CYCLES);
  localparam logic [PIX_W-1:0] PIX_FULL   = PIX_W'(NUM_PIXELS);

  typedef enum logic [1:0] {
    ST_LATCH,
    ST_IDLE,
    ST_SEND
  } state_e;

  state_e             state_q, state_d;
  logic [23:0]        shift_q, shift_d;
  logic [4:0]         bit_idx_q, bit_idx_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [PIX_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic               from_rst_q, from_rst_d;
  logic               data_out_q, data_out_d;
  logic               frame_done_q, frame_done_d;

  logic bit_end;
  logic pixel_end;
  logic xfer;

  assign bit_end     = (state_q == ST_SEND) && (cyc_q == BIT_LAST);
  assign pixel_end   = bit_end && (bit_idx_q == '0);
  assign pixel_ready = (state_q == ST_IDLE) || (pixel_end && (pix_cnt_q < PIX_FULL));
  assign xfer        = pixel_valid && pixel_ready;
  assign busy        = (state_q != ST_IDLE);
  assign data_out    = data_out_q;
  assign frame_done  = frame_done_q;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    cyc_d        = cyc_q;
    pix_cnt_d    = pix_cnt_q;
    from_rst_d   = from_rst_q;
    frame_done_d = 1'b0;

    case (state_q)
      ST_LATCH: begin
        if (cyc_q == LATCH_LAST) begin
          state_d      = ST_IDLE;
          cyc_d        = '0;
          pix_cnt_d    = '0;
          frame_done_d = !from_rst_q;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (xfer) begin
          state_d   = ST_SEND;
          shift_d   = pixel_data;
          bit_idx_d = 5'd23;
          cyc_d     = '0;
          pix_cnt_d = pix_cnt_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (!bit_end) begin
          cyc_d = cyc_q + 1'b1;
        end else begin
          cyc_d = '0;
          if (bit_idx_q != '0) begin
            shift_d   = {shift_q[22:0], 1'b0};
            bit_idx_d = bit_idx_q - 1'b1;
          end else if (xfer) begin
            shift_d   = pixel_data;
            bit_idx_d = 5'd23;
            pix_cnt_d = pix_cnt_q + 1'b1;
          end else if (pix_cnt_q == PIX_FULL) begin
            state_d    = ST_LATCH;
            from_rst_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_LATCH;
        cyc_d   = '0;
      end
    endcase

    // Decoded from next-state so the first high cycle lands right after the transfer edge.
    data_out_d = (state_d == ST_SEND) && (cyc_d < (shift_d[23] ? T1H : T0H));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_LATCH;
      shift_q      <= '0;
      bit_idx_q    <= '0;
      cyc_q        <= '0;
      pix_cnt_q    <= '0;
      from_rst_q   <= 1'b1;
      data_out_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      cyc_q        <= cyc_d;
      pix_cnt_q    <= pix_cnt_d;
      from_rst_q   <= from_rst_d;
      data_out_q   <= data_out_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_ws2812_serializer.sv
// Bench for ws2812_serializer: waveform-queue reference model checked every cycle,
// a pixel table, and hand sequences for reset, back-to-back, stall and frame end.
module tb_ws2812_serializer;

  localparam int NUM = 64;
  localparam int BITC = 15;
  localparam int LATCH = 720;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        data_out;
  logic        busy;
  logic        frame_done;

  int tests = 0;
  int fails = 0;

  ws2812_serializer #(
    .NUM_PIXELS(64), .BIT_CYCLES(15), .T0H_CYCLES(4), .T1H_CYCLES(8), .LATCH_CYCLES(720)
  ) dut (
    .clk(clk), .rst(rst), .pixel_data(pixel_data), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .data_out(data_out), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: the waveform still to be emitted, as a queue of output levels.
  bit wave[$];
  int kind = 0;       // 0 idle, 1 pixel, 2 latch
  int cnt = 0;
  bit from_rst = 1'b1;
  bit m_fd = 1'b0;

  typedef struct {
    logic [23:0] pix;
    int          hi_total;
    int          first_hi;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    return (kind == 0) || (kind == 1 && wave.size() == 1 && cnt < NUM);
  endfunction

  function automatic void push_pixel(input logic [23:0] p);
    for (int b = 23; b >= 0; b--)
      for (int c = 0; c < BITC; c++)
        wave.push_back(c < (p[b] ? 8 : 4));
  endfunction

  function automatic void push_latch();
    for (int c = 0; c < LATCH; c++) wave.push_back(1'b0);
  endfunction

  task automatic step();
    bit xfer;
    xfer = pixel_valid && m_ready() && !rst;
    @(posedge clk);
    if (rst) begin
      wave.delete();
      push_latch();
      kind = 2; from_rst = 1'b1; cnt = 0; m_fd = 1'b0;
    end else begin
      m_fd = 1'b0;
      if (wave.size() != 0) void'(wave.pop_front());
      if (wave.size() == 0) begin
        if (xfer) begin
          push_pixel(pixel_data); kind = 1; cnt++;
        end else if (kind == 1 && cnt == NUM) begin
          push_latch(); kind = 2; from_rst = 1'b0;
        end else if (kind == 2) begin
          kind = 0; cnt = 0; m_fd = !from_rst;
        end else begin
          kind = 0;
        end
      end
    end
    #1;
    check("cycle{dout,rdy,busy,fd}", {28'd0, data_out, pixel_ready, busy, frame_done},
          {28'd0, (wave.size() != 0) ? wave[0] : 1'b0, m_ready(), kind != 0, m_fd});
  endtask

  // Counts cycles with pixel_ready low, starting from the current cycle.
  task automatic latch_len(input string name, input int exp_len);
    int n = 0;
    int fdn = 0;
    while (!pixel_ready && n < 2000) begin
      if (frame_done) fdn++;
      n++;
      step();
    end
    check({name, "_len"}, n, exp_len);
    check({name, "_no_fd"}, fdn, 0);
    check({name, "_idle_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    int hi, first, hi_a, hi_b, busy_lo, acc, fdn, stall, n;
    logic rdy;

    tbl[0] = '{24'h800001, 104, 8};
    tbl[1] = '{24'hFFFFFF, 192, 8};
    tbl[2] = '{24'h000000,  96, 4};
    tbl[3] = '{24'h0F0F0F, 144, 4};
    tbl[4] = '{24'hAAAAAA, 144, 8};
    tbl[5] = '{24'h000001, 100, 4};

    rst = 1'b1; pixel_valid = 1'b0; pixel_data = '0;
    #1;
    step(); step();
    check("rst_dout", {31'd0, data_out}, 0);
    check("rst_ready", {31'd0, pixel_ready}, 0);
    check("rst_busy", {31'd0, busy}, 1);
    rst = 1'b0;
    latch_len("post_reset_latch", LATCH);

    // Single pixels from IDLE
    for (int i = 0; i < 6; i++) begin
      pixel_valid = 1'b1; pixel_data = tbl[i].pix;
      step();
      pixel_valid = 1'b0; pixel_data = 24'($urandom);
      hi = 0; first = 0;
      for (int c = 0; c < 24 * BITC; c++) begin
        hi += int'(data_out);
        if (c < BITC) first += int'(data_out);
        step();
      end
      check($sformatf("tbl%0d_hi_total", i), hi, tbl[i].hi_total);
      check($sformatf("tbl%0d_first_hi", i), first, tbl[i].first_hi);
      check($sformatf("tbl%0d_end_dout", i), {31'd0, data_out}, 0);
      check($sformatf("tbl%0d_end_busy", i), {31'd0, busy}, 0);
    end

    // Back-to-back pixels with valid held
    pixel_valid = 1'b1; pixel_data = 24'hFFFFFF;
    step();
    pixel_data = 24'h000000;
    hi_a = 0; hi_b = 0; busy_lo = 0;
    for (int c = 0; c < 2 * 24 * BITC; c++) begin
      if (c < 24 * BITC) hi_a += int'(data_out); else hi_b += int'(data_out);
      if (!busy) busy_lo++;
      step();
      if (c == 24 * BITC - 1) pixel_valid = 1'b0;
    end
    check("b2b_hi_first", hi_a, 192);
    check("b2b_hi_second", hi_b, 96);
    check("b2b_no_gap", busy_lo, 0);
    check("b2b_end_busy", {31'd0, busy}, 0);

    // Reset in the middle of a high pulse
    pixel_valid = 1'b1; pixel_data = 24'hFFFFFF;
    step();
    pixel_valid = 1'b0;
    repeat (50) step();
    check("midrst_pre_high", {31'd0, data_out}, 1);
    rst = 1'b1; pixel_valid = 1'b1;
    step();
    rst = 1'b0; pixel_valid = 1'b0;
    check("midrst_dout", {31'd0, data_out}, 0);
    check("midrst_busy", {31'd0, busy}, 1);
    latch_len("midrst_latch", LATCH);

    // Full frame, valid held high except a stall after pixel 3
    acc = 0; fdn = 0; stall = 0; n = 0;
    while (fdn == 0 && n < 30000) begin
      pixel_valid = (stall == 0);
      pixel_data = 24'($urandom);
      rdy = pixel_ready;
      if (pixel_valid && rdy) begin
        acc++;
        if (acc == 3) stall = 24 * BITC + 100 + 1;
      end
      step();
      if (stall > 0) stall--;
      if (frame_done) fdn++;
      n++;
    end
    check("frame_pixels_accepted", acc, NUM);
    check("frame_done_seen", fdn, 1);
    check("frame_ready_after", {31'd0, pixel_ready}, 1);
    step();
    check("frame_done_one_cycle", {31'd0, frame_done}, 0);
    pixel_valid = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 12000; c++) begin
      pixel_valid = ($urandom_range(0, 3) != 0);
      pixel_data = 24'($urandom);
      rst = ($urandom_range(0, 4999) == 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
